// File: rtl/daq_tx_pkg.sv
// Shared types and helpers for the DAQ transmit arbiter: FSM state encoding,
// default packet timing and the saturating counter increment.
package daq_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_STREAM    = 3'd3,
    ST_ABORT     = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  localparam int DEF_PKT_WORDS = 100;
  localparam int DEF_TMO_CYC   = 32;
  localparam int DEF_IFG_CYC   = 4;

  localparam int CNT_W     = 8;
  localparam int PKT_CNT_W = 16;
  localparam int WCNT_W    = 7;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: returns the first set request at or after
// ptr, wrapping cyclically, plus a flag telling whether any request is set.
module rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      for (int i = 0; i < N; i++) begin
        if (((int'(ptr) + k) == i || (int'(ptr) + k) == (i + N)) && req[i]) begin
          idx   = W'(i);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/daq_tx_arb.sv
// Round-robin sequencer that shares one GbE MAC transmit path between NREQ
// packet builders, enforcing packet length, data-start timeout and frame gap.
module daq_tx_arb
  import daq_tx_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int PKT_WORDS = DEF_PKT_WORDS,
  parameter int TMO_CYC   = DEF_TMO_CYC,
  parameter int IFG_CYC   = DEF_IFG_CYC,
  parameter int GW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        REQ,
  input  logic [16*NREQ-1:0]     DIN,
  input  logic [NREQ-1:0]        DVLD,
  input  logic                   MAC_ACK,
  output logic                   TX_REQ,
  output logic [NREQ-1:0]        ACK,
  output logic [15:0]            TXD,
  output logic                   TXD_VLD,
  output logic                   BUSY,
  output logic [GW-1:0]          GRANT,
  output logic [PKT_CNT_W-1:0]   PKT_CNT,
  output logic [CNT_W-1:0]       TMO_CNT,
  output logic [CNT_W-1:0]       LEN_ERR_CNT,
  output logic [2:0]             DBG_STATE
);

  // Handshake: TX_REQ stays high from the first ARM cycle until MAC_ACK (a
  // one-cycle pulse, honoured only in ARM) or the granted REQ falling; the
  // accepted start is relayed as a one-cycle ACK one clock later, after which
  // the source streams words qualified by DVLD until its first idle cycle.

  localparam int TW = $clog2(TMO_CYC) + 1;
  localparam int GPW = $clog2(IFG_CYC) + 1;
  localparam logic [TW-1:0]     TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [GPW-1:0]    GAP_LAST = GPW'(IFG_CYC - 1);
  localparam logic [WCNT_W-1:0] PW       = WCNT_W'(PKT_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  state_t              state;
  logic [GW-1:0]       grant;
  logic [GW-1:0]       ptr;
  logic [GW-1:0]       next_ptr;
  logic [GW-1:0]       pick_idx;
  logic                pick_vld;
  logic [TW-1:0]       timer;
  logic [GPW-1:0]      gap_cnt;
  logic [WCNT_W-1:0]   wcnt;
  logic                from_wait;
  logic                tx_req_r;
  logic [NREQ-1:0]     ack_r;
  logic [15:0]         txd_r;
  logic                txd_vld_r;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [CNT_W-1:0]    len_err_cnt;
  logic [15:0]         din_g;
  logic                dvld_g;
  logic                req_g;

  rr_pick #(.N(NREQ), .W(GW)) u_pick (
    .req   (REQ),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  // Only the granted source is ever looked at; everything else is ignored.
  always_comb begin
    din_g  = '0;
    dvld_g = 1'b0;
    req_g  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == GW'(i)) begin
        din_g  = DIN[16*i +: 16];
        dvld_g = DVLD[i];
        req_g  = REQ[i];
      end
    end
  end

  assign next_ptr = (grant == GW'(NREQ - 1)) ? '0 : grant + GW'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      grant       <= '0;
      ptr         <= '0;
      timer       <= '0;
      gap_cnt     <= '0;
      wcnt        <= '0;
      from_wait   <= 1'b0;
      tx_req_r    <= 1'b0;
      ack_r       <= '0;
      txd_r       <= '0;
      txd_vld_r   <= 1'b0;
      pkt_cnt     <= '0;
      tmo_cnt     <= '0;
      len_err_cnt <= '0;
    end else begin
      ack_r <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant    <= pick_idx;
            tx_req_r <= 1'b1;
            state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (MAC_ACK) begin
            ack_r    <= NREQ'(1) << grant;
            tx_req_r <= 1'b0;
            timer    <= '0;
            state    <= ST_WAIT_DATA;
          end else if (!req_g) begin
            tx_req_r <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_WAIT_DATA: begin
          // The first valid word is already forwarded here as word 1.
          if (dvld_g) begin
            txd_r     <= din_g;
            txd_vld_r <= 1'b1;
            wcnt      <= WCNT_W'(1);
            state     <= ST_STREAM;
          end else if (timer == TMO_LAST) begin
            from_wait <= 1'b1;
            state     <= ST_ABORT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_STREAM: begin
          if (dvld_g) begin
            if (wcnt == WCNT_MAX) begin
              txd_vld_r   <= 1'b0;
              len_err_cnt <= sat_inc(len_err_cnt);
              from_wait   <= 1'b0;
              state       <= ST_ABORT;
            end else begin
              wcnt      <= wcnt + WCNT_W'(1);
              txd_r     <= din_g;
              txd_vld_r <= 1'b1;
            end
          end else begin
            txd_vld_r <= 1'b0;
            pkt_cnt   <= pkt_cnt + PKT_CNT_W'(1);
            if (wcnt != PW) len_err_cnt <= sat_inc(len_err_cnt);
            ptr       <= next_ptr;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end
        end
        ST_ABORT: begin
          if (from_wait) tmo_cnt <= sat_inc(tmo_cnt);
          txd_vld_r <= 1'b0;
          ptr       <= next_ptr;
          gap_cnt   <= '0;
          state     <= ST_GAP;
        end
        ST_GAP: begin
          txd_vld_r <= 1'b0;
          tx_req_r  <= 1'b0;
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + GPW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign TX_REQ      = tx_req_r;
  assign ACK         = ack_r;
  assign TXD         = txd_r;
  assign TXD_VLD     = txd_vld_r;
  assign BUSY        = (state != ST_IDLE);
  assign GRANT       = grant;
  assign PKT_CNT     = pkt_cnt;
  assign TMO_CNT     = tmo_cnt;
  assign LEN_ERR_CNT = len_err_cnt;
  assign DBG_STATE   = state;

endmodule

// File: doc/daq_tx_arb.md
Name: daq_tx_arb

Overview:
- Round-robin arbiter/sequencer sharing a single GbE MAC transmit path between NREQ packet sources (per-channel-group sample packet builders, each a 16-bit TXD/TXD_VLD stream gated by a one-cycle TXACK start strobe).
- Grants one source at a time, requests the MAC, forwards the MAC acknowledge as that source's TXACK, and muxes its stream to the MAC.
- Enforces packet-length, data-start timeout and inter-frame gap; keeps diagnostic counters for slow control.

Parameters:
- NREQ, 2, number of packet sources (2..8).
- PKT_WORDS, 100, expected 16-bit words per packet (data + CRC + trailer).
- TMO_CYC, 32, max cycles from forwarded ACK to first valid word.
- IFG_CYC, 4, idle cycles enforced after every packet or abort.

Ports:
- CLK  in  1  readout clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  NREQ  source i has a complete packet queued (L1A buffer not empty).
- DIN  in  16*NREQ  source i data, bits [16i+15:16i].
- DVLD  in  NREQ  source i word valid.
- MAC_ACK  in  1  MAC accepts the frame start; one-cycle pulse.
- TX_REQ  out  1  frame request to MAC.
- ACK  out  NREQ  one-hot one-cycle TXACK to the granted source.
- TXD  out  16  muxed data to MAC.
- TXD_VLD  out  1  muxed valid to MAC.
- BUSY  out  1  state != IDLE.
- GRANT  out  clog2(NREQ) index of current or last granted source.
- PKT_CNT  out  16  completed packets, wraps.
- TMO_CNT  out  8  timeout aborts, saturates at 255.
- LEN_ERR_CNT  out  8  packets with length != PKT_WORDS, saturates.

Behaviour:
- Reset: state IDLE; TX_REQ=0, ACK=0, TXD=0, TXD_VLD=0, GRANT=0, priority pointer=0, all counters 0. Async assert; reset mid-packet drops TX_REQ/TXD_VLD immediately; no counter updates.
- States: IDLE, ARM, WAIT_DATA, STREAM, ABORT, GAP.
- IDLE: if any REQ set, pick first set index at or after the pointer, cyclically. Latch GRANT; go ARM next cycle.
- ARM: TX_REQ=1 (registered, first high in ARM's first cycle).
  - MAC_ACK=1: ACK[GRANT]=1 next cycle for exactly one cycle; drop TX_REQ; clear timer; go WAIT_DATA.
  - REQ[GRANT] falls before MAC_ACK: drop TX_REQ; return to IDLE; pointer unchanged.
  - No timeout in ARM.
- WAIT_DATA: timer increments each cycle.
  - DVLD[GRANT]=1: go STREAM; the word counts as word 1.
  - Timer reaches TMO_CYC-1 with no DVLD: go ABORT.
- STREAM: TXD<=DIN[GRANT], TXD_VLD<=DVLD[GRANT], 1-cycle registered latency. Non-granted sources are never forwarded.
  - Word counter (7-bit, saturating at 127) counts DVLD cycles.
  - End of packet = first DVLD[GRANT]=0 cycle. PKT_CNT+1; LEN_ERR_CNT+1 (saturating) if count != PKT_WORDS; pointer=GRANT+1 mod NREQ; go GAP.
  - Count reaching 127 with DVLD still high: force TXD_VLD=0, LEN_ERR_CNT+1, go ABORT.
- ABORT: one cycle. TMO_CNT+1 saturating, but only if entered from WAIT_DATA. Pointer advances past GRANT. Go GAP.
- GAP: IFG_CYC cycles, TX_REQ=0, TXD_VLD=0; then IDLE. REQ is ignored during GAP.
- Simultaneous events:
  - REQ rising while in GAP is served in the following IDLE.
  - MAC_ACK outside ARM is ignored.
  - DVLD from non-granted sources is ignored in all states.
- Per-source grant latency with all sources requesting: at most NREQ packets.

Decomposition:
- Package daq_tx_pkg: state enum, PKT_WORDS/TMO_CYC/IFG_CYC defaults, counter widths, saturating-increment function.
- One natural sub-module: rr_pick, combinational round-robin first-set finder (REQ, pointer → index, valid), reusable by other arbiters.

Test Plan:
- NREQ=2, REQ=01; MAC_ACK 3 cycles after TX_REQ; source 0 sends 100 words → ACK[0] one pulse; TXD equals DIN delayed 1 cycle; PKT_CNT=1, LEN_ERR_CNT=0; TX_REQ low for ≥4 cycles after.
- REQ=11 held, 4 packets → grant order 0,1,0,1; PKT_CNT=4.
- Granted source never asserts DVLD → abort 32 cycles after ACK; TMO_CNT=1; other source granted next.
- Source sends 98 words → LEN_ERR_CNT=1, PKT_CNT=1. Source holds DVLD for 130 cycles → TXD_VLD forced low at word 127; LEN_ERR_CNT increments.
- REQ[0] dropped in ARM before MAC_ACK → TX_REQ deasserts; no ACK; pointer still 0.
- RST pulsed mid-STREAM at word 50 → TXD_VLD=0 and counters=0 same cycle; next request serves source 0.
